// File: rtl/rng_sched_pkg.sv
// Shared types for the TRNG parameter-sweep sequencer.
package rng_sched_pkg;

  localparam int DW = 32;

  typedef enum logic [3:0] {
    IDLE, SETTLE, GO, WAIT_RUN, RUN_ST, DRAIN, CAPTURE, EMIT, ABORT_WAIT
  } state_t;

  typedef struct packed {
    logic [DW-1:0] param;
    logic [DW-1:0] stats;
    logic          timeout;
    logic          over;
  } result_t;

endpackage

// File: rtl/rng_sched_timer.sv
// Loadable down-counter; sticks at zero and flags it. Reused for settle and timeout.
module rng_sched_timer #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                cnt_q <= '0;
    else if (load_i)        cnt_q <= val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rng_sweep_sched.sv
// Steps the TRNG parameter across a range, one GO/RUN/STATS cycle per step,
// and streams one {param, stats} result beat per step.
module rng_sweep_sched
  import rng_sched_pkg::*;
#(
  parameter int STEP_W   = 16,
  parameter int SETTLE_W = 16,
  parameter int TMO_W    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SWEEP_START,
  input  logic                SWEEP_ABORT,
  input  logic [31:0]         PARAM_BASE,
  input  logic [31:0]         PARAM_STEP,
  input  logic [STEP_W-1:0]   NUM_STEPS,
  input  logic [31:0]         BYTES_PER_STEP,
  input  logic [SETTLE_W-1:0] SETTLE_CYCLES,
  input  logic [TMO_W-1:0]    TIMEOUT_CYCLES,
  output logic                RNG_GO,
  output logic                RNG_STOP,
  input  logic                RNG_RUN,
  input  logic                RNG_OVER,
  output logic [31:0]         RNG_SEND_BYTES,
  output logic [31:0]         RNG_PARAMETER,
  input  logic [31:0]         RNG_STATS,
  output logic [63:0]         RES_TDATA,
  output logic [1:0]          RES_TUSER,
  output logic                RES_TLAST,
  output logic                RES_TVALID,
  input  logic                RES_TREADY,
  output logic                SWEEP_BUSY,
  output logic                SWEEP_DONE,
  output logic                SWEEP_ABORTED,
  output logic                ERR_TIMEOUT,
  output logic [STEP_W-1:0]   STEP_IDX
);

  state_t              state_q, state_d;
  logic [31:0]         param_q, param_d;
  logic [STEP_W-1:0]   idx_q, idx_d;
  result_t             res_q, res_d;
  logic                tflag_q, tflag_d;
  logic                done_q, done_d, abrt_q, abrt_d, errt_q, errt_d;
  logic [31:0]         pstep_q, bytes_q;
  logic [STEP_W-1:0]   nsteps_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [TMO_W-1:0]    tmo_q;

  logic             tmr_load, tmr_zero, stop;
  logic [TMO_W-1:0] tmr_val;
  logic             start_ok, is_last, tmo_exp;

  assign start_ok = (state_q == IDLE) && SWEEP_START && !SWEEP_ABORT;
  assign is_last  = (idx_q == nsteps_q - 1'b1);
  assign tmo_exp  = (tmo_q != '0) && tmr_zero;

  rng_sched_timer #(.W(TMO_W)) u_tmr (
    .CLK(CLK), .RST(RST), .load_i(tmr_load), .val_i(tmr_val), .zero_o(tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    param_d  = param_q;
    idx_d    = idx_q;
    res_d    = res_q;
    tflag_d  = tflag_q;
    done_d   = done_q;
    abrt_d   = abrt_q;
    errt_d   = errt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    stop     = 1'b0;
    case (state_q)
      IDLE: if (start_ok) begin
        done_d = 1'b0;
        abrt_d = 1'b0;
        errt_d = 1'b0;
        if (NUM_STEPS == '0) done_d = 1'b1;
        else begin
          param_d = PARAM_BASE;
          idx_d   = '0;
          // zero settle goes straight to GO so GO lands SETTLE+1 cycles after START
          if (SETTLE_CYCLES == '0) state_d = GO;
          else begin
            state_d  = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = TMO_W'(SETTLE_CYCLES - 1'b1);
          end
        end
      end
      SETTLE: if (tmr_zero) state_d = GO;
      GO: begin
        tmr_load = 1'b1;
        tmr_val  = tmo_q - 1'b1;
        tflag_d  = 1'b0;
        state_d  = WAIT_RUN;
      end
      WAIT_RUN, RUN_ST: begin
        if (state_q == RUN_ST && !RNG_RUN) state_d = CAPTURE;
        else if (tmo_exp) begin
          stop    = 1'b1;
          tflag_d = 1'b1;
          errt_d  = 1'b1;
          state_d = DRAIN;
        end else if (state_q == WAIT_RUN && RNG_RUN) state_d = RUN_ST;
      end
      DRAIN:   if (!RNG_RUN) state_d = CAPTURE;
      CAPTURE: begin
        res_d   = '{param: param_q, stats: RNG_STATS, timeout: tflag_q, over: RNG_OVER};
        state_d = EMIT;
      end
      EMIT: if (RES_TREADY) begin
        if (is_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          param_d = param_q + pstep_q;
          idx_d   = idx_q + 1'b1;
          if (settle_q == '0) state_d = GO;
          else begin
            state_d  = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = TMO_W'(settle_q - 1'b1);
          end
        end
      end
      ABORT_WAIT: if (!RNG_RUN) begin
        done_d  = 1'b1;
        abrt_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A GO already issued means the core may be starting even with RUN still low.
    if (SWEEP_ABORT && state_q != IDLE && state_q != ABORT_WAIT) begin
      param_d  = param_q;
      idx_d    = idx_q;
      tmr_load = 1'b0;
      if (RNG_RUN || state_q == GO || state_q == WAIT_RUN) begin
        stop    = 1'b1;
        state_d = ABORT_WAIT;
      end else begin
        done_d  = 1'b1;
        abrt_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      param_q  <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      tflag_q  <= 1'b0;
      done_q   <= 1'b0;
      abrt_q   <= 1'b0;
      errt_q   <= 1'b0;
      pstep_q  <= '0;
      bytes_q  <= '0;
      nsteps_q <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      param_q <= param_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      tflag_q <= tflag_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      errt_q  <= errt_d;
      if (start_ok) begin
        pstep_q  <= PARAM_STEP;
        bytes_q  <= BYTES_PER_STEP;
        nsteps_q <= NUM_STEPS;
        settle_q <= SETTLE_CYCLES;
        tmo_q    <= TIMEOUT_CYCLES;
      end
    end
  end

  assign RNG_GO         = (state_q == GO);
  assign RNG_STOP       = stop;
  assign RNG_SEND_BYTES = bytes_q;
  assign RNG_PARAMETER  = param_q;
  assign RES_TDATA      = {res_q.param, res_q.stats};
  assign RES_TUSER      = {res_q.timeout, res_q.over};
  assign RES_TVALID     = (state_q == EMIT);
  assign RES_TLAST      = (state_q == EMIT) && is_last;
  assign SWEEP_BUSY     = (state_q != IDLE);
  assign SWEEP_DONE     = done_q;
  assign SWEEP_ABORTED  = abrt_q;
  assign ERR_TIMEOUT    = errt_q;
  assign STEP_IDX       = idx_q;

endmodule

// File: tb/tb_rng_sweep_sched.sv
// Randomized bench for rng_sweep_sched with a behavioural TRNG core and a
// per-sweep expected-beat list built from base + k*step.
module tb_rng_sweep_sched;

  localparam int STEP_W = 16, SETTLE_W = 16, TMO_W = 32;

  logic                CLK = 1'b0, RST = 1'b1;
  logic                SWEEP_START = 1'b0, SWEEP_ABORT = 1'b0;
  logic [31:0]         PARAM_BASE = '0, PARAM_STEP = '0, BYTES_PER_STEP = '0;
  logic [STEP_W-1:0]   NUM_STEPS = '0;
  logic [SETTLE_W-1:0] SETTLE_CYCLES = '0;
  logic [TMO_W-1:0]    TIMEOUT_CYCLES = '0;
  logic                RNG_GO, RNG_STOP, RNG_RUN = 1'b0;
  logic                RNG_OVER;
  logic [31:0]         RNG_SEND_BYTES, RNG_PARAMETER, RNG_STATS;
  logic [63:0]         RES_TDATA;
  logic [1:0]          RES_TUSER;
  logic                RES_TLAST, RES_TVALID, RES_TREADY = 1'b1;
  logic                SWEEP_BUSY, SWEEP_DONE, SWEEP_ABORTED, ERR_TIMEOUT;
  logic [STEP_W-1:0]   STEP_IDX;

  rng_sweep_sched #(.STEP_W(STEP_W), .SETTLE_W(SETTLE_W), .TMO_W(TMO_W)) dut (
    .CLK(CLK), .RST(RST), .SWEEP_START(SWEEP_START), .SWEEP_ABORT(SWEEP_ABORT),
    .PARAM_BASE(PARAM_BASE), .PARAM_STEP(PARAM_STEP), .NUM_STEPS(NUM_STEPS),
    .BYTES_PER_STEP(BYTES_PER_STEP), .SETTLE_CYCLES(SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .RNG_GO(RNG_GO), .RNG_STOP(RNG_STOP),
    .RNG_RUN(RNG_RUN), .RNG_OVER(RNG_OVER), .RNG_SEND_BYTES(RNG_SEND_BYTES),
    .RNG_PARAMETER(RNG_PARAMETER), .RNG_STATS(RNG_STATS), .RES_TDATA(RES_TDATA),
    .RES_TUSER(RES_TUSER), .RES_TLAST(RES_TLAST), .RES_TVALID(RES_TVALID),
    .RES_TREADY(RES_TREADY), .SWEEP_BUSY(SWEEP_BUSY), .SWEEP_DONE(SWEEP_DONE),
    .SWEEP_ABORTED(SWEEP_ABORTED), .ERR_TIMEOUT(ERR_TIMEOUT), .STEP_IDX(STEP_IDX)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // core model: stats and overflow are fixed functions of the applied parameter
  assign RNG_STATS = RNG_PARAMETER + 32'd1;
  assign RNG_OVER  = RNG_PARAMETER[4];

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [63:0] data; logic [1:0] user; logic last;} beat_t;
  beat_t expq[$];

  int  run_len = 1, cur_tmo = 0, cur_settle = 0, rdy_mode = 0;
  bit  stuck = 0, aborting = 0;
  logic [31:0] cur_bytes = '0;
  int  go_cnt = 0, stop_cnt = 0, beat_cnt = 0, busy_cnt = 0, stall_cnt = 0;
  int  go_cyc = 0, lat_ref = 0, m_dly = 0, m_cnt = 0, stop_pend = 0, hold_n = 0;
  bit  lat_vld = 0, hold_prev = 0;
  logic [63:0] held = '0;

  // monitor + TRNG core model, all at the falling edge
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      RNG_RUN = 1'b0; m_dly = 0; stop_pend = 0; hold_prev = 0; lat_vld = 0;
      expq.delete();
    end else begin
      if (SWEEP_BUSY) busy_cnt++;
      if (SWEEP_ABORT && SWEEP_BUSY) begin aborting = 1; lat_vld = 0; end
      if (SWEEP_START && !SWEEP_BUSY && !SWEEP_ABORT) begin
        aborting = 0; lat_ref = cyc; lat_vld = 1;
      end
      if (RNG_GO) begin
        go_cnt++; go_cyc = cyc;
        if (lat_vld && !aborting) chk("go_lat", cyc - lat_ref, cur_settle + 1);
        chk("send_bytes", RNG_SEND_BYTES, cur_bytes);
        lat_vld = 0;
      end
      if (RNG_STOP) begin
        stop_cnt++;
        if (!aborting) chk("tmo_lat", cyc - go_cyc, cur_tmo);
      end
      if (RES_TVALID && hold_prev) chk("tdata_hold", RES_TDATA, held);
      hold_prev = RES_TVALID && !RES_TREADY;
      held = RES_TDATA;
      if (RES_TVALID && !RES_TREADY) stall_cnt++;
      if (RES_TVALID && RES_TREADY) begin
        beat_cnt++;
        if (expq.size() == 0) chk("extra_beat", 1, 0);
        else begin
          beat_t b;
          b = expq.pop_front();
          chk("tdata", RES_TDATA, b.data);
          chk("tuser", RES_TUSER, b.user);
          chk("tlast", RES_TLAST, b.last);
          if (!b.last && !aborting) begin lat_ref = cyc; lat_vld = 1; end
        end
      end
      if (RNG_STOP) begin stop_pend = 3; m_dly = 0; end
      if (RNG_GO) begin m_dly = 2; stop_pend = 0; end
      else if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) begin RNG_RUN = 1'b1; m_cnt = run_len; end
      end else if (RNG_RUN) begin
        if (stop_pend > 0) begin
          stop_pend--;
          if (stop_pend == 0) RNG_RUN = 1'b0;
        end else if (!stuck) begin
          m_cnt--;
          if (m_cnt <= 0) RNG_RUN = 1'b0;
        end
      end
    end
  end

  // TREADY: 0 always ready, 1 random, 2 stall the first beat 100 cycles
  initial forever begin
    @(posedge CLK); #1;
    if (rdy_mode != 2) hold_n = 0;
    case (rdy_mode)
      1: RES_TREADY = 1'($urandom_range(0, 1));
      2: if (RES_TVALID && hold_n < 100) begin RES_TREADY = 1'b0; hold_n++; end
         else RES_TREADY = 1'b1;
      default: RES_TREADY = 1'b1;
    endcase
  end

  task automatic start_sweep(input logic [31:0] base, input logic [31:0] step,
                             input int n, input int nexp, input int settle,
                             input int tmo, input int rlen, input bit stk);
    cur_settle = settle; cur_tmo = tmo; run_len = rlen; stuck = stk;
    cur_bytes = $urandom;
    for (int k = 0; k < nexp; k++) begin
      beat_t b;
      logic [31:0] p;
      p = base + step * 32'(k);
      b.data = {p, p + 32'd1};
      b.user = {stk && (tmo != 0), p[4]};
      b.last = (k == n - 1);
      expq.push_back(b);
    end
    @(posedge CLK); #1;
    PARAM_BASE = base; PARAM_STEP = step; NUM_STEPS = STEP_W'(n);
    SETTLE_CYCLES = SETTLE_W'(settle); TIMEOUT_CYCLES = TMO_W'(tmo);
    BYTES_PER_STEP = cur_bytes; SWEEP_START = 1'b1;
    @(posedge CLK); #1;
    SWEEP_START = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (SWEEP_BUSY && i < budget) begin @(posedge CLK); #1; i++; end
    chk(tag, SWEEP_BUSY, 0);
  endtask

  task automatic end_checks(input int n, input bit exp_err);
    chk("q_empty", expq.size(), 0);
    chk("done", SWEEP_DONE, 1);
    chk("aborted", SWEEP_ABORTED, 0);
    chk("err_tmo", ERR_TIMEOUT, exp_err);
    chk("step_idx", STEP_IDX, n - 1);
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_ctl"}, {RNG_GO, RNG_STOP, RES_TUSER, RES_TLAST, RES_TVALID, SWEEP_BUSY,
                       SWEEP_DONE, SWEEP_ABORTED, ERR_TIMEOUT, STEP_IDX}, 0);
    chk({tag, "_tdata"}, RES_TDATA, 0);
    chk({tag, "_cfg"}, {RNG_SEND_BYTES, RNG_PARAMETER}, 0);
  endtask

  initial begin
    int g0, b0, bz0, s0, st0, i;
    repeat (3) @(posedge CLK);
    #1 zero_checks("rst");
    RST = 1'b0;

    // nominal three-step sweep
    start_sweep(32'h10, 32'h10, 3, 3, 4, 0, 20, 0);
    wait_idle("t1_idle", 1000);
    end_checks(3, 0);

    // empty sweep
    g0 = go_cnt; b0 = beat_cnt; bz0 = busy_cnt;
    start_sweep(32'h0, 32'h0, 0, 0, 0, 0, 1, 0);
    chk("n0_done", SWEEP_DONE, 1);
    chk("n0_busy", SWEEP_BUSY, 0);
    repeat (20) @(posedge CLK);
    #1;
    chk("n0_go", go_cnt - g0, 0);
    chk("n0_beats", beat_cnt - b0, 0);
    chk("n0_busy_seen", busy_cnt - bz0, 0);

    // stuck RUN, every step times out
    s0 = stop_cnt;
    start_sweep(32'h100, 32'h10, 2, 2, 3, 50, 0, 1);
    wait_idle("t3_idle", 1000);
    end_checks(2, 1);
    chk("t3_stops", stop_cnt - s0, 2);
    stuck = 0;

    // back-pressure on the first beat
    rdy_mode = 2;
    st0 = stall_cnt;
    start_sweep(32'h5000, 32'h3, 2, 2, 1, 0, 5, 0);
    wait_idle("t4_idle", 1000);
    end_checks(2, 0);
    chk("t4_stall", stall_cnt - st0, 100);
    rdy_mode = 0;

    // abort mid-run on the second step
    s0 = stop_cnt; b0 = beat_cnt;
    start_sweep(32'h40, 32'h8, 4, 1, 2, 0, 200, 0);
    i = 0;
    while (!(STEP_IDX == 1 && RNG_RUN) && i < 1000) begin @(posedge CLK); #1; i++; end
    chk("t5_reach", (STEP_IDX == 1 && RNG_RUN), 1);
    repeat (5) @(posedge CLK);
    #1 SWEEP_ABORT = 1'b1;
    @(posedge CLK);
    #1 SWEEP_ABORT = 1'b0;
    wait_idle("t5_idle", 500);
    chk("t5_stops", stop_cnt - s0, 1);
    chk("t5_aborted", SWEEP_ABORTED, 1);
    chk("t5_done", SWEEP_DONE, 1);
    chk("t5_run", RNG_RUN, 0);
    repeat (30) @(posedge CLK);
    #1;
    chk("t5_beats", beat_cnt - b0, 1);
    chk("t5_q", expq.size(), 0);

    // parameter wrap, then reset in the middle of a run
    start_sweep(32'hFFFF_FFF0, 32'h10, 2, 2, 2, 0, 8, 0);
    wait_idle("t6_idle", 1000);
    end_checks(2, 0);
    start_sweep(32'h1234, 32'h1, 3, 0, 0, 0, 100, 0);
    i = 0;
    while (!RNG_RUN && i < 200) begin @(posedge CLK); #1; i++; end
    chk("t6_run", RNG_RUN, 1);
    RST = 1'b1;
    #2 zero_checks("midrst");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // randomized sweeps with random back-pressure
    rdy_mode = 1;
    for (int it = 0; it < 8; it++) begin
      int n, tmo;
      n   = $urandom_range(1, 4);
      tmo = ($urandom_range(0, 1) != 0) ? 0 : 2000;
      start_sweep($urandom, $urandom, n, n, $urandom_range(0, 6), tmo,
                  $urandom_range(1, 30), 0);
      wait_idle("rnd_idle", 3000);
      end_checks(n, 0);
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d limit=90000", cyc);
    $fatal(1);
  end

endmodule
